// File: rtl/key_event_arbiter_if.sv
// Event stream from the key arbiter to the UI/menu controller.
// A transfer happens on a clk edge where ev_valid && ev_ready.
interface key_event_arbiter_if #(
  parameter int ID_W = 2
) ();
  logic            ev_valid;
  logic            ev_ready;
  logic [ID_W-1:0] ev_key;
  logic [1:0]      ev_type;

  modport master (
    output ev_valid,
    output ev_key,
    output ev_type,
    input  ev_ready
  );

  modport slave (
    input  ev_valid,
    input  ev_key,
    input  ev_type,
    output ev_ready
  );
endinterface

// File: rtl/key_event_arbiter.sv
// Classifies per-key press/release pulses into PRESS/SHORT_REL/LONG_HOLD/LONG_REL
// events and serialises them round-robin onto one valid/ready stream.
module key_event_arbiter #(
  parameter int N_KEYS      = 4,
  parameter int ID_W        = 2,
  parameter int LONG_CYCLES = 50_000_000,
  parameter int CNT_W       = 26
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_KEYS-1:0]   press_down,
  input  logic [N_KEYS-1:0]   press_up,
  key_event_arbiter_if.master ev_if,
  output logic                overflow,
  input  logic                ovf_clr
);

  typedef enum logic [1:0] {
    ST_UP   = 2'd0,
    ST_HELD = 2'd1,
    ST_LONG = 2'd2
  } key_state_e;

  localparam logic [1:0] EV_PRESS     = 2'b00;
  localparam logic [1:0] EV_SHORT_REL = 2'b01;
  localparam logic [1:0] EV_LONG_HOLD = 2'b10;
  localparam logic [1:0] EV_LONG_REL  = 2'b11;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

  // Index base+step modulo N_KEYS (N_KEYS need not be a power of two).
  function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int step);
    int sum;
    sum = int'(base) + step;
    sum = (sum >= N_KEYS) ? (sum - N_KEYS) : sum;
    return ID_W'(sum);
  endfunction

  key_state_e       state_r    [N_KEYS];
  key_state_e       state_nx_s [N_KEYS];
  logic [CNT_W-1:0] cnt_r      [N_KEYS];
  logic [CNT_W-1:0] cnt_nx_s   [N_KEYS];
  logic [1:0]       raise_t_s  [N_KEYS];
  logic [1:0]       slot_t_r   [N_KEYS];
  logic [N_KEYS-1:0] raise_s;
  logic [N_KEYS-1:0] slot_v_r;
  logic [N_KEYS-1:0] grant_s;
  logic [N_KEYS-1:0] drop_s;

  logic            found_s;
  logic [ID_W-1:0] gnt_idx_s;
  logic [1:0]      gnt_type_s;
  logic            out_free_s;
  logic [ID_W-1:0] rr_ptr_r;
  logic            ev_valid_r;
  logic [ID_W-1:0] ev_key_r;
  logic [1:0]      ev_type_r;
  logic            overflow_r;

  // Per-key classifier next state, hold counter and raised event.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      state_nx_s[i] = state_r[i];
      cnt_nx_s[i]   = cnt_r[i];
      raise_s[i]    = 1'b0;
      raise_t_s[i]  = EV_PRESS;
      case (state_r[i])
        ST_UP: begin
          if (press_down[i]) begin
            state_nx_s[i] = ST_HELD;
            cnt_nx_s[i]   = '0;
            raise_s[i]    = 1'b1;
            raise_t_s[i]  = EV_PRESS;
          end else begin
            state_nx_s[i] = ST_UP;
          end
        end
        ST_HELD: begin
          // A simultaneous press_down masks press_up, so the key stays held.
          if (press_up[i] && !press_down[i]) begin
            state_nx_s[i] = ST_UP;
            cnt_nx_s[i]   = '0;
            raise_s[i]    = 1'b1;
            raise_t_s[i]  = EV_SHORT_REL;
          end else if (cnt_r[i] == LONG_LAST) begin
            state_nx_s[i] = ST_LONG;
            cnt_nx_s[i]   = cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
            raise_s[i]    = 1'b1;
            raise_t_s[i]  = EV_LONG_HOLD;
          end else begin
            cnt_nx_s[i]   = cnt_r[i] + {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_LONG: begin
          if (press_up[i] && !press_down[i]) begin
            state_nx_s[i] = ST_UP;
            cnt_nx_s[i]   = '0;
            raise_s[i]    = 1'b1;
            raise_t_s[i]  = EV_LONG_REL;
          end else begin
            state_nx_s[i] = ST_LONG;
          end
        end
        default: begin
          state_nx_s[i] = ST_UP;
          cnt_nx_s[i]   = '0;
        end
      endcase
    end
  end

  // Round-robin search for the first pending slot starting at rr_ptr.
  always_comb begin
    found_s    = 1'b0;
    gnt_idx_s  = '0;
    gnt_type_s = EV_PRESS;
    for (int k = 0; k < N_KEYS; k++) begin
      if (!found_s && slot_v_r[wrap_idx(rr_ptr_r, k)]) begin
        found_s    = 1'b1;
        gnt_idx_s  = wrap_idx(rr_ptr_r, k);
        gnt_type_s = slot_t_r[wrap_idx(rr_ptr_r, k)];
      end else begin
        found_s    = found_s;
      end
    end
  end

  assign out_free_s = !ev_valid_r || ev_if.ev_ready;

  // Grant and drop decisions per slot.
  always_comb begin
    for (int i = 0; i < N_KEYS; i++) begin
      grant_s[i] = out_free_s && found_s && (gnt_idx_s == ID_W'(i));
      drop_s[i]  = raise_s[i] && slot_v_r[i] && !grant_s[i];
    end
  end

  // Classifier state, hold counters and pending slots.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_r[i]  <= ST_UP;
        cnt_r[i]    <= '0;
        slot_t_r[i] <= 2'b00;
      end
      slot_v_r <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        state_r[i] <= state_nx_s[i];
        cnt_r[i]   <= cnt_nx_s[i];
        // A granted slot is free again this edge, so a new event may refill it.
        if (raise_s[i] && !drop_s[i]) begin
          slot_v_r[i] <= 1'b1;
          slot_t_r[i] <= raise_t_s[i];
        end else if (grant_s[i]) begin
          slot_v_r[i] <= 1'b0;
        end else begin
          slot_v_r[i] <= slot_v_r[i];
        end
      end
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ev_valid_r <= 1'b0;
      ev_key_r   <= '0;
      ev_type_r  <= 2'b00;
      rr_ptr_r   <= '0;
    end else if (out_free_s) begin
      if (found_s) begin
        ev_valid_r <= 1'b1;
        ev_key_r   <= gnt_idx_s;
        ev_type_r  <= gnt_type_s;
        rr_ptr_r   <= wrap_idx(gnt_idx_s, 1);
      end else begin
        ev_valid_r <= 1'b0;
      end
    end else begin
      ev_valid_r <= ev_valid_r;
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
    end else if (|drop_s) begin
      overflow_r <= 1'b1;
    end else if (ovf_clr) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

  assign ev_if.ev_valid = ev_valid_r;
  assign ev_if.ev_key   = ev_key_r;
  assign ev_if.ev_type  = ev_type_r;
  assign overflow       = overflow_r;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed self-checking bench for key_event_arbiter with LONG_CYCLES=100.
module tb_key_event_arbiter;

  localparam logic [1:0] PRESS     = 2'b00;
  localparam logic [1:0] SHORT_REL = 2'b01;
  localparam logic [1:0] LONG_HOLD = 2'b10;
  localparam logic [1:0] LONG_REL  = 2'b11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] press_down;
  logic [3:0] press_up;
  logic       overflow;
  logic       ovf_clr;

  int n_checks = 0;
  int n_fail   = 0;
  int n_events = 0;
  int ev_base;

  key_event_arbiter_if #(.ID_W(2)) ev_if ();

  key_event_arbiter #(
    .N_KEYS(4), .ID_W(2), .LONG_CYCLES(100), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .press_down(press_down), .press_up(press_up),
    .ev_if(ev_if), .overflow(overflow), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && ev_if.ev_valid && ev_if.ev_ready) n_events <= n_events + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_ev(input string tag, input logic [1:0] key, input logic [1:0] typ);
    check({tag, "_valid"}, 32'(ev_if.ev_valid), 32'd1);
    check({tag, "_key"},   32'(ev_if.ev_key),   32'(key));
    check({tag, "_type"},  32'(ev_if.ev_type),  32'(typ));
  endtask

  task automatic pulse_down(input logic [3:0] mask);
    press_down = mask;
    tick();
    press_down = 4'b0000;
  endtask

  task automatic pulse_up(input logic [3:0] mask);
    press_up = mask;
    tick();
    press_up = 4'b0000;
  endtask

  initial begin
    rst_n = 1'b0; press_down = 4'b0000; press_up = 4'b0000;
    ovf_clr = 1'b0; ev_if.ev_ready = 1'b1;
    repeat (3) tick();
    check("rst_valid", 32'(ev_if.ev_valid), 32'd0);
    check("rst_key",   32'(ev_if.ev_key),   32'd0);
    check("rst_type",  32'(ev_if.ev_type),  32'd0);
    check("rst_ovf",   32'(overflow),       32'd0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("rst_exit_valid", 32'(ev_if.ev_valid), 32'd0);

    // Test 1: short press on key 0
    repeat (6) tick();
    ev_base = n_events;
    pulse_down(4'b0001);
    check("t1_latency", 32'(ev_if.ev_valid), 32'd0);
    tick();
    check_ev("t1_press", 2'd0, PRESS);
    tick();
    check("t1_idle", 32'(ev_if.ev_valid), 32'd0);
    repeat (37) tick();
    pulse_up(4'b0001);
    check("t1_rel_latency", 32'(ev_if.ev_valid), 32'd0);
    tick();
    check_ev("t1_srel", 2'd0, SHORT_REL);
    repeat (5) tick();
    check("t1_count", 32'(n_events - ev_base), 32'd2);

    // Test 2: long hold on key 2
    ev_base = n_events;
    pulse_down(4'b0100);
    tick();
    check_ev("t2_press", 2'd2, PRESS);
    repeat (99) tick();
    check("t2_not_early", 32'(ev_if.ev_valid), 32'd0);
    tick();
    check_ev("t2_long_hold", 2'd2, LONG_HOLD);
    repeat (150) tick();
    pulse_up(4'b0100);
    tick();
    check_ev("t2_long_rel", 2'd2, LONG_REL);
    repeat (3) tick();
    check("t2_count", 32'(n_events - ev_base), 32'd3);

    // Test 3: all keys at once, round-robin from pointer 0
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    pulse_down(4'b1111);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_ev("t3_press", 2'(i), PRESS);
    end
    tick();
    check("t3_drain", 32'(ev_if.ev_valid), 32'd0);
    pulse_up(4'b1111);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_ev("t3_srel", 2'(i), SHORT_REL);
    end
    tick();
    pulse_down(4'b1111);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_ev("t3_press2", 2'(i), PRESS);
    end
    pulse_up(4'b1111);
    repeat (6) tick();
    check("t3_end_idle", 32'(ev_if.ev_valid), 32'd0);

    // Test 4: backpressure, slot full, overflow and clear on key 1
    ev_if.ev_ready = 1'b0;
    pulse_down(4'b0010);
    tick();
    check_ev("t4_hold_press", 2'd1, PRESS);
    repeat (3) tick();
    pulse_up(4'b0010);
    tick();
    check_ev("t4_stall", 2'd1, PRESS);
    check("t4_no_ovf", 32'(overflow), 32'd0);
    pulse_down(4'b0010);
    check("t4_ovf_set", 32'(overflow), 32'd1);
    check_ev("t4_stall2", 2'd1, PRESS);
    ev_if.ev_ready = 1'b1;
    tick();
    check_ev("t4_slot_kept", 2'd1, SHORT_REL);
    tick();
    check("t4_no_third", 32'(ev_if.ev_valid), 32'd0);
    check("t4_ovf_sticky", 32'(overflow), 32'd1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t4_ovf_clr", 32'(overflow), 32'd0);

    // Test 5: simultaneous down/up on key 3
    press_down = 4'b1000;
    press_up   = 4'b1000;
    tick();
    press_down = 4'b0000;
    press_up   = 4'b0000;
    tick();
    check_ev("t5_press", 2'd3, PRESS);
    tick();
    check("t5_only_press", 32'(ev_if.ev_valid), 32'd0);
    pulse_up(4'b1000);
    tick();
    check_ev("t5_held", 2'd3, SHORT_REL);
    tick();

    // Test 6: reset with key 1 held, events pending and overflow set
    ev_if.ev_ready = 1'b0;
    pulse_down(4'b0101);
    tick();
    check_ev("t6_pre", 2'd0, PRESS);
    pulse_up(4'b0001);
    pulse_down(4'b0001);
    check("t6_ovf_pre", 32'(overflow), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(ev_if.ev_valid), 32'd0);
    check("t6_rst_ovf",   32'(overflow),       32'd0);
    tick();
    ev_if.ev_ready = 1'b1;
    rst_n = 1'b1;
    repeat (4) tick();
    check("t6_exit_valid", 32'(ev_if.ev_valid), 32'd0);
    pulse_up(4'b0010);
    repeat (3) tick();
    check("t6_up_ignored", 32'(ev_if.ev_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
